mem_resp_unit: RTL
==================

// Module: mem_resp_unit
// PURPOSE
// Memory-side end of the load/store queue issue path. Accepts one issued LSQ entry at a time.
// Forms the aligned D-cache request and holds it until dmem_resp. Formats load data and
// broadcasts the completion on the CDB. busy feeds the LSQ d_cache_in_use input, so the
// LSQ never dequeues while an access is outstanding or a result awaits CDB grant.
// PARAMETERS
// PD_W    6   physical register tag width
// ROB_W   4   ROB index width
// PORTS
// clk          in   1      clock; all state updates on rising edge
// rst_n        in   1      asynchronous reset, active low
// flush        in   1      branch mispredict flush; synchronous
// req_valid    in   1      LSQ dequeued an entry this cycle
// req_is_load  in   1      entry is a load
// req_is_store in   1      entry is a store
// req_funct3   in   3      000 B, 001 H, 010 W, 100 BU, 101 HU
// req_rs1_val  in   32     base register value
// req_rs2_val  in   32     store data
// req_imm      in   32     sign-extended offset
// req_pd       in   PD_W   destination physical register; 0 for stores
// req_rd       in   5      architectural destination
// req_rob      in   ROB_W  ROB entry of the op
// busy         out  1      request accepted and not yet retired from this unit
// dmem_addr    out  32     word-aligned address {ea[31:2],2'b00}
// dmem_rmask   out  4      load byte mask
// dmem_wmask   out  4      store byte mask
// dmem_wdata   out  32     store data shifted into lane position
// dmem_rdata   in   32     load word
// dmem_resp    in   1      one-cycle completion pulse from D-cache
// cdb_valid    out  1      result ready for CDB
// cdb_grant    in   1      CDB arbiter took this unit's result this cycle
// cdb_pd       out  PD_W   tag broadcast
// cdb_rd       out  5      architectural destination
// cdb_rob      out  ROB_W  ROB entry to mark done
// cdb_value    out  32     formatted load value; 0 for stores
// cdb_misalign out  1      access was misaligned; no memory request was issued
// BEHAVIOUR
// Reset (rst_n=0, asynchronous): state=IDLE; every output is 0.
// States: IDLE, MEM (request outstanding), DONE (result held), DRAIN (flushed request outstanding).
// Effective address: ea = req_rs1_val + req_imm, modulo 2^32.
// Byte lane offset: off = ea[1:0].
// Masks:
//   B/BU: 4'b0001<<off
//   H/HU: 4'b0011<<off
//   W:    4'b1111
// Misaligned: H/HU with off[0]=1, or W with off!=0.
// IDLE, req_valid, aligned:
//   Register the request; next state MEM.
//   dmem_addr/rmask (load) or wmask/wdata (store) appear the following cycle.
//   The request is held stable until dmem_resp. rmask and wmask are never both nonzero.
// IDLE, req_valid, misaligned:
//   Next state DONE with cdb_value=0 and cdb_misalign=1; no dmem activity.
// Store data: wdata = rs2_val << (8*off).
// MEM, dmem_resp:
//   Capture the formatted result; drop masks to 0 in the same registered update; next state DONE.
//   Load formatting: shift dmem_rdata right by 8*off; B/H sign-extend; BU/HU zero-extend.
// DONE: cdb_valid=1, outputs stable until cdb_grant; on grant, next state IDLE and cdb_valid=0.
// Timing: load with 1-cycle cache response gives request at N+1, dmem_resp at N+2, cdb_valid at N+3.
// busy = (state != IDLE). A new req_valid may be accepted in the cycle after the grant.
// req_valid while busy is a protocol violation; it is ignored and no state changes.
// flush:
//   In IDLE, DONE or DRAIN (no new request pending): next state IDLE, cdb_valid=0.
//   In MEM without dmem_resp: next state DRAIN. Masks stay held until dmem_resp; then IDLE.
//   The drained response is never broadcast.
//   In MEM with dmem_resp in the same cycle: response discarded, next state IDLE.
//   flush with req_valid in IDLE: request dropped.
// busy stays 1 in DRAIN, so the LSQ cannot issue into a cache that is still servicing the old access.
// TESTING
// 1 LB: rs1=0x1000, imm=3, rdata=0x80112233 -> dmem_addr=0x1000, rmask=1000, cdb_value=0xFFFFFF80.
// 2 SH: rs1=0x2002, imm=0, rs2=0xABCD1234 -> wmask=1100, wdata=0x12340000.
//   After dmem_resp: cdb_valid with pd=0, value=0.
// 3 LW at 0x1001 -> no rmask or wmask ever asserted; next cycle cdb_valid=1, cdb_misalign=1.
// 4 LHU hold: LHU 0x3002, rdata=0xBEEF0000, cdb_grant held low 5 cycles.
//   -> cdb_value=0x0000BEEF stable throughout; busy=1 until the cycle after grant.
// 5 Flush in flight: flush 1 cycle after LW is issued, dmem_resp 4 cycles later.
//   -> rmask held until resp; busy=1 until resp; no cdb_valid.
// 6 Async reset: rst_n low mid-MEM, no clock edge -> busy, masks and cdb_valid drop to 0 immediately.

Source files
------------

// File: rtl/mem_resp_unit.sv
// Memory response unit: issues one aligned D-cache access per LSQ entry,
// formats the load result and holds it on the CDB until granted.
module mem_resp_unit #(
    parameter int PD_W  = 6,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    input  logic             req_is_load,
    input  logic             req_is_store,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_rs1_val,
    input  logic [31:0]      req_rs2_val,
    input  logic [31:0]      req_imm,
    input  logic [PD_W-1:0]  req_pd,
    input  logic [4:0]       req_rd,
    input  logic [ROB_W-1:0] req_rob,
    output logic             busy,
    output logic [31:0]      dmem_addr,
    output logic [3:0]       dmem_rmask,
    output logic [3:0]       dmem_wmask,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_resp,
    output logic             cdb_valid,
    input  logic             cdb_grant,
    output logic [PD_W-1:0]  cdb_pd,
    output logic [4:0]       cdb_rd,
    output logic [ROB_W-1:0] cdb_rob,
    output logic [31:0]      cdb_value,
    output logic             cdb_misalign
);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        DONE,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] ea;
    logic [1:0]  off;
    logic [3:0]  req_mask;
    logic        req_misalign;
    logic [31:0] wdata_sh;
    logic        accept;
    logic        capture;

    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        load_q;
    logic [31:0] rdata_sh;
    logic [31:0] load_fmt;

    assign ea       = req_rs1_val + req_imm;
    assign off      = ea[1:0];
    assign wdata_sh = req_rs2_val << {off, 3'b000};

    // funct3[1:0] encodes access size; bit 2 only selects zero-extension
    always_comb begin
        req_mask     = 4'b1111;
        req_misalign = 1'b0;
        unique case (req_funct3[1:0])
            2'b00: req_mask = 4'b0001 << off;
            2'b01: begin
                req_mask     = 4'b0011 << off;
                req_misalign = off[0];
            end
            default: req_misalign = (off != 2'b00);
        endcase
    end

    assign rdata_sh = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_fmt = rdata_sh;
        unique case (funct3_q)
            3'b000:  load_fmt = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  load_fmt = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  load_fmt = {24'b0, rdata_sh[7:0]};
            3'b101:  load_fmt = {16'b0, rdata_sh[15:0]};
            default: load_fmt = rdata_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = req_misalign ? DONE : MEM;
                end
            end
            MEM: begin
                if (flush) begin
                    state_next = dmem_resp ? IDLE : DRAIN;
                end else if (dmem_resp) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (flush || cdb_grant) state_next = IDLE;
            end
            DRAIN: begin
                if (flush || dmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_addr    <= '0;
            dmem_rmask   <= '0;
            dmem_wmask   <= '0;
            dmem_wdata   <= '0;
            off_q        <= '0;
            funct3_q     <= '0;
            load_q       <= 1'b0;
            cdb_pd       <= '0;
            cdb_rd       <= '0;
            cdb_rob      <= '0;
            cdb_value    <= '0;
            cdb_misalign <= 1'b0;
        end else if (accept) begin
            off_q        <= off;
            funct3_q     <= req_funct3;
            load_q       <= req_is_load;
            cdb_pd       <= req_pd;
            cdb_rd       <= req_rd;
            cdb_rob      <= req_rob;
            cdb_value    <= '0;
            cdb_misalign <= req_misalign;
            dmem_rmask   <= '0;
            dmem_wmask   <= '0;
            if (!req_misalign) begin
                dmem_addr  <= {ea[31:2], 2'b00};
                dmem_rmask <= req_is_load ? req_mask : 4'b0000;
                dmem_wmask <= (req_is_store && !req_is_load) ? req_mask : 4'b0000;
                dmem_wdata <= req_is_store ? wdata_sh : 32'b0;
            end
        end else if (capture) begin
            dmem_rmask <= '0;
            dmem_wmask <= '0;
            cdb_value  <= load_q ? load_fmt : 32'b0;
        end else if (state_next == IDLE) begin
            // returning idle leaves the cache port and CDB fields quiet
            dmem_rmask   <= '0;
            dmem_wmask   <= '0;
            cdb_pd       <= '0;
            cdb_rd       <= '0;
            cdb_rob      <= '0;
            cdb_value    <= '0;
            cdb_misalign <= 1'b0;
        end
    end

    assign busy      = (state != IDLE);
    assign cdb_valid = (state == DONE);

endmodule
